// File: rtl/axis_mm_burst_bridge.sv
// axis_mm_burst_bridge: AXI-Stream to AXI4 write-burst bridge (beat FIFO, 4 KiB-safe INCR bursts, B tracking, busy/error status; AXIS_MM_BRESP_ERR_EN enables bresp error capture)
module axis_mm_burst_bridge #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 34,
  parameter int AXI_ID = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_OUTSTANDING = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                  cfg_base_addr_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [5:0]            m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [KEEP_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [5:0]            m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  status_busy,
  output logic                  status_error,
  output logic [7:0]            status_err_count
);
  localparam int AS = $clog2(KEEP_WIDTH);
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(KEEP_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t r_state, w_next;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [FA:0] r_wr, r_rd, r_lasts, w_count;
  logic [OW-1:0] r_out;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_eff;
  logic [8:0] r_len, r_beat, w_awlen;
  logic [12:0] w_to_4k, w_len_a, w_len;
  logic w_push, w_pop, w_aw_hs, w_b_hs, w_load, w_start, w_wlast, w_head_last, w_unused;
  assign w_count = r_wr - r_rd;
  assign s_axis_tready = !rst && (w_count < (FA+1)'(FIFO_DEPTH));
  assign w_push = s_axis_tvalid && s_axis_tready;
  assign w_aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_pop = m_axi_wvalid && m_axi_wready;
  assign w_b_hs = m_axi_bvalid && m_axi_bready;
  assign w_awlen = r_len - 9'd1;
  assign w_wlast = r_beat == w_awlen;
  assign w_head_last = r_mem[r_rd[FA-1:0]][EW-1];
  // A load in the same cycle as a burst start must size that burst from the new address
  assign w_load = r_state == IDLE && cfg_base_addr_valid;
  assign w_ptr_eff = w_load ? (cfg_base_addr & ~LOW_MASK) : r_ptr;
  assign w_to_4k = (13'h1000 - {1'b0, w_ptr_eff[11:0]}) >> AS;
  assign w_len_a = 13'(w_count) < w_to_4k ? 13'(w_count) : w_to_4k;
  assign w_len = w_len_a < 13'(MAX_BURST_LEN) ? w_len_a : 13'(MAX_BURST_LEN);
  assign w_start = (w_count >= (FA+1)'(MAX_BURST_LEN) || r_lasts != 0) && r_out < OW'(MAX_OUTSTANDING);
  always_comb begin
    w_next = r_state == IDLE ? (w_start ? ADDR : IDLE) :
             r_state == ADDR ? (w_aw_hs ? DATA : ADDR) :
             (w_pop && w_wlast ? IDLE : DATA);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wr <= '0;
      r_rd <= '0;
      r_lasts <= '0;
      r_out <= '0;
      r_ptr <= '0;
      r_len <= '0;
      r_beat <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_lasts <= r_lasts + (FA+1)'(w_push && s_axis_tlast) - (FA+1)'(w_pop && w_head_last);
      r_out <= r_out + OW'(w_aw_hs) - OW'(w_b_hs && r_out != 0);
      if (w_load) r_ptr <= w_ptr_eff;
      if (r_state == IDLE && w_start) begin
        r_len <= w_len[8:0];
        r_beat <= '0;
      end
      if (w_pop) begin
        r_beat <= r_beat + 9'd1;
        if (w_wlast) r_ptr <= r_ptr + (ADDR_WIDTH'(r_len) << AS);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[FA-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end
  assign m_axi_awid = 6'(AXI_ID);
  assign m_axi_awaddr = r_ptr;
  assign m_axi_awlen = w_awlen[7:0];
  assign m_axi_awsize = 3'(AS);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot = 3'd0;
  assign m_axi_awvalid = !rst && r_state == ADDR;
  assign m_axi_wvalid = !rst && r_state == DATA;
  assign m_axi_wdata = r_mem[r_rd[FA-1:0]][DATA_WIDTH-1:0];
  assign m_axi_wstrb = r_mem[r_rd[FA-1:0]][DATA_WIDTH +: KEEP_WIDTH];
  assign m_axi_wlast = m_axi_wvalid && w_wlast;
  assign m_axi_bready = !rst;
  assign status_busy = r_state != IDLE || w_count != 0 || r_out != 0;
`ifdef AXIS_MM_BRESP_ERR_EN
  logic r_err;
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_b_hs && m_axi_bresp != 2'b00) begin
      r_err <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
  assign status_error = r_err;
  assign status_err_count = r_err_cnt;
  assign w_unused = ^{m_axi_bid, w_awlen[8], w_len[12:9]};
`else
  assign status_error = 1'b0;
  assign status_err_count = 8'd0;
  assign w_unused = ^{m_axi_bid, m_axi_bresp, w_awlen[8], w_len[12:9]};
`endif
endmodule

// File: tb/tb_axis_mm_burst_bridge.sv
// tb_axis_mm_burst_bridge: directed self-checking bench for axis_mm_burst_bridge
module tb_axis_mm_burst_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic [33:0] cfg_base_addr = '0;
  logic cfg_base_addr_valid = 1'b0;
  logic [63:0] tdata = '0;
  logic [7:0] tkeep = '0;
  logic tlast = 1'b0, tvalid = 1'b0, tready;
  logic [5:0] awid;
  logic [33:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst;
  logic awlock, awvalid, awready = 1'b1;
  logic [3:0] awcache;
  logic [63:0] wdata;
  logic [7:0] wstrb;
  logic wlast, wvalid, wready = 1'b1;
  logic [1:0] bresp = 2'b00;
  logic bvalid = 1'b0, bready;
  logic busy, err;
  logic [7:0] err_cnt;
  int n_assert = 0, n_fail = 0;
  logic [33:0] aw_addr_q[$];
  logic [7:0] aw_len_q[$];
  logic [63:0] w_data_q[$];
  logic [7:0] w_strb_q[$];
  logic w_last_q[$];
  always #5 clk = ~clk;
  axis_mm_burst_bridge dut (
    .clk(clk), .rst(rst),
    .cfg_base_addr(cfg_base_addr), .cfg_base_addr_valid(cfg_base_addr_valid),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(6'd0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .status_busy(busy), .status_error(err), .status_err_count(err_cnt)
  );
  always @(posedge clk) begin
    if (awvalid && awready) begin
      aw_addr_q.push_back(awaddr);
      aw_len_q.push_back(awlen);
    end
    if (wvalid && wready) begin
      w_data_q.push_back(wdata);
      w_strb_q.push_back(wstrb);
      w_last_q.push_back(wlast);
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
    int waited = 0;
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    while (!tready && waited < 400) begin
      tick();
      waited++;
    end
    chk("push_tready", 64'(tready), 64'd1);
    tick();
    tvalid = 1'b0; tlast = 1'b0;
  endtask
  task automatic wait_w(input int n);
    for (int i = 0; i < 600 && w_data_q.size() < n; i++) tick();
    chk("w_beats", 64'(w_data_q.size()), 64'(n));
    tick(); tick();
  endtask
  task automatic send_b(input logic [1:0] r);
    bvalid = 1'b1; bresp = r;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
  endtask
  task automatic load(input logic [33:0] a);
    cfg_base_addr = a; cfg_base_addr_valid = 1'b1;
    tick();
    cfg_base_addr_valid = 1'b0;
  endtask
  task automatic clear_q();
    aw_addr_q.delete(); aw_len_q.delete();
    w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
  endtask
  initial begin
    int acc;
    logic [7:0] exp_err;
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc;
    logic exp_err;
    logic [7:0] exp_cnt;
`ifdef AXIS_MM_BRESP_ERR_EN
    exp_err = 1'b1; exp_cnt = 8'd1;
`else
    exp_err = 1'b0; exp_cnt = 8'd0;
`endif
    // reset state
    tick(); tick();
    chk("rst_awvalid", 64'(awvalid), 0);
    chk("rst_wvalid", 64'(wvalid), 0);
    chk("rst_wlast", 64'(wlast), 0);
    chk("rst_tready", 64'(tready), 0);
    chk("rst_bready", 64'(bready), 0);
    rst = 1'b0;
    tick();
    chk("idle_tready", 64'(tready), 1);
    chk("idle_bready", 64'(bready), 1);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_err", 64'(err), 0);
    chk("idle_err_cnt", 64'(err_cnt), 0);
    chk("awsize", 64'(awsize), 3);
    chk("awburst", 64'(awburst), 1);
    chk("awid", 64'(awid), 0);
    chk("awlock_cache_prot", 64'({awlock, awcache, awprot}), 0);
    // 16 full beats at 0x1000
    load(34'h1000);
    for (int i = 0; i < 16; i++) push(64'h1000_0000 + 64'(i), 8'hFF, 1'b0);
    wait_w(16);
    chk("b1_aw_cnt", 64'(aw_addr_q.size()), 1);
    chk("b1_awaddr", 64'(aw_addr_q[0]), 64'h1000);
    chk("b1_awlen", 64'(aw_len_q[0]), 15);
    for (int i = 0; i < 16; i++) chk("b1_wdata", w_data_q[i], 64'h1000_0000 + 64'(i));
    chk("b1_wlast14", 64'(w_last_q[14]), 0);
    chk("b1_wlast15", 64'(w_last_q[15]), 1);
    chk("b1_busy_out", 64'(busy), 1);
    send_b(2'b00);
    chk("b1_busy_done", 64'(busy), 0);
    clear_q();
    push(64'hAA, 8'hFF, 1'b1);
    wait_w(1);
    chk("ptr_awaddr", 64'(aw_addr_q[0]), 64'h1080);
    chk("ptr_awlen", 64'(aw_len_q[0]), 0);
    chk("ptr_wlast", 64'(w_last_q[0]), 1);
    send_b(2'b00);
    // short packet flushed by tlast with partial keep
    clear_q();
    load(34'h2000);
    push(64'h21, 8'hFF, 1'b0);
    push(64'h22, 8'hFF, 1'b0);
    push(64'h23, 8'h0F, 1'b1);
    wait_w(3);
    chk("b2_awaddr", 64'(aw_addr_q[0]), 64'h2000);
    chk("b2_awlen", 64'(aw_len_q[0]), 2);
    chk("b2_wstrb0", 64'(w_strb_q[0]), 64'hFF);
    chk("b2_wstrb2", 64'(w_strb_q[2]), 64'h0F);
    chk("b2_wlast1", 64'(w_last_q[1]), 0);
    chk("b2_wlast2", 64'(w_last_q[2]), 1);
    chk("b2_wdata2", w_data_q[2], 64'h23);
    send_b(2'b00);
    chk("b2_err", 64'(err), 0);
    // 4 KiB boundary split
    clear_q();
    load(34'h0FF0);
    for (int i = 0; i < 16; i++) push(64'h4B00 + 64'(i), 8'hFF, i == 15);
    wait_w(16);
    chk("b3_aw_cnt", 64'(aw_addr_q.size()), 2);
    chk("b3_awaddr0", 64'(aw_addr_q[0]), 64'h0FF0);
    chk("b3_awlen0", 64'(aw_len_q[0]), 1);
    chk("b3_awaddr1", 64'(aw_addr_q[1]), 64'h1000);
    chk("b3_awlen1", 64'(aw_len_q[1]), 13);
    chk("b3_wlast1", 64'(w_last_q[1]), 1);
    chk("b3_wlast2", 64'(w_last_q[2]), 0);
    chk("b3_wlast15", 64'(w_last_q[15]), 1);
    chk("b3_wdata9", w_data_q[9], 64'h4B09);
    // second B carries SLVERR
    send_b(2'b00);
    send_b(2'b10);
    chk("bresp_err", 64'(err), 64'(exp_err));
    chk("bresp_err_cnt", 64'(err_cnt), 64'(exp_cnt));
    // AW backpressure fills the FIFO
    clear_q();
    load(34'h3000);
    awready = 1'b0;
    acc = 0;
    tvalid = 1'b1; tkeep = 8'hFF; tlast = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tdata = 64'h3000_0000 + 64'(acc);
      if (tready) acc++;
      tick();
    end
    tvalid = 1'b0;
    chk("bp_accepted", 64'(acc), 32);
    chk("bp_tready", 64'(tready), 0);
    chk("bp_awvalid", 64'(awvalid), 1);
    chk("bp_awaddr", 64'(awaddr), 64'h3000);
    chk("bp_awlen", 64'(awlen), 15);
    chk("bp_no_w", 64'(w_data_q.size()), 0);
    awready = 1'b1;
    for (int i = 32; i < 40; i++) push(64'h3000_0000 + 64'(i), 8'hFF, i == 39);
    wait_w(40);
    chk("bp_aw_cnt", 64'(aw_addr_q.size()), 3);
    chk("bp_awaddr1", 64'(aw_addr_q[1]), 64'h3080);
    chk("bp_awaddr2", 64'(aw_addr_q[2]), 64'h3100);
    chk("bp_awlen1", 64'(aw_len_q[1]), 15);
    chk("bp_awlen2", 64'(aw_len_q[2]), 7);
    for (int i = 0; i < 40; i++) chk("bp_wdata", w_data_q[i], 64'h3000_0000 + 64'(i));
    chk("bp_wlast31", 64'(w_last_q[31]), 1);
    chk("bp_wlast39", 64'(w_last_q[39]), 1);
    send_b(2'b00); send_b(2'b00); send_b(2'b00);
    chk("bp_busy", 64'(busy), 0);
    // reset in the middle of a burst
    clear_q();
    load(34'h4000);
    wready = 1'b0;
    for (int i = 0; i < 16; i++) push(64'h4000 + 64'(i), 8'hFF, 1'b0);
    tick(); tick(); tick();
    chk("mr_wvalid", 64'(wvalid), 1);
    wready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mr_beats4", 64'(w_data_q.size()), 4);
    chk("mr_wdata5", wdata, 64'h4004);
    rst = 1'b1;
    #1;
    chk("mr_rst_wvalid", 64'(wvalid), 0);
    chk("mr_rst_awvalid", 64'(awvalid), 0);
    tick();
    chk("mr_next_wvalid", 64'(wvalid), 0);
    chk("mr_next_awvalid", 64'(awvalid), 0);
    rst = 1'b0;
    tick();
    chk("mr_busy", 64'(busy), 0);
    chk("mr_tready", 64'(tready), 1);
    chk("mr_err", 64'(err), 0);
    chk("mr_err_cnt", 64'(err_cnt), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("mr_beats_after", 64'(w_data_q.size()), 4);
    chk("mr_aw_after", 64'(aw_addr_q.size()), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
